// File: rtl/fp16_vec64_packer.sv
// fp16_vec64_packer
//   Gathers a stream of FP16 elements into one LANES-wide vector for the
//   adder tree. The packer fills lanes 0, 1, 2 and so on. It closes the
//   vector when the last lane is written or when an element arrives with
//   s_last set. It then presents the vector until the consumer accepts it.
//   Lanes that were never written read as +0. A short vector therefore
//   sums to the same value as its real elements.
//
// Ports
//   clk, rst          single clock; asynchronous active-high reset
//   s_valid/s_ready   upstream element handshake
//   s_data, s_last    FP16 element; s_last marks the end of a short vector
//   m_x               packed vector, lane k at [k*DW +: DW]
//   m_valid/m_ready   downstream vector handshake
//   m_count           number of real elements in m_x (1..LANES)

// One storage lane. Zeroed when its vector is handed off, so a later
// shorter vector never shows leftover data in the lanes it does not use.
module fp16_packer_lane #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          we,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module fp16_vec64_packer #(
    parameter int LANES = 64,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DW-1:0]       s_data,
    input  logic                s_last,
    output logic [LANES*DW-1:0] m_x,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [6:0]          m_count
);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                     state, state_d;
    logic   [IW-1:0]            idx;
    logic                       rdy_q;
    logic                       accept, close, drain, at_end;
    logic   [LANES-1:0][DW-1:0] lane_q;

    // s_ready is a register. It is low during reset and rises on the first
    // edge after reset. It never depends combinationally on m_ready.
    assign s_ready = rdy_q;
    assign accept  = s_valid && rdy_q;
    assign at_end  = (idx == IW'(LANES - 1));
    assign close   = accept && (s_last || at_end);
    assign drain   = (state == FULL) && m_ready;
    assign m_valid = (state == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            FILL:    if (close)   state_d = FULL;
            FULL:    if (m_ready) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q   <= 1'b0;
            idx     <= '0;
            m_count <= '0;
        end else begin
            rdy_q <= (state_d == FILL);
            // The index returns to 0 as soon as the vector closes. It is
            // then already correct for the first element after the handoff.
            if (close)       idx <= '0;
            else if (accept) idx <= idx + 1'b1;
            if (close)       m_count <= {{(7-IW){1'b0}}, idx} + 7'd1;
            else if (drain)  m_count <= '0;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fp16_packer_lane #(.DW(DW)) u_lane (
            .clk (clk),
            .rst (rst),
            .clr (drain),
            .we  (accept && (idx == IW'(k))),
            .d   (s_data),
            .q   (lane_q[k])
        );
    end

    assign m_x = lane_q;
endmodule

// File: tb/tb_fp16_vec64_packer.sv
module tb_fp16_vec64_packer;
    localparam int LANES = 64;
    localparam int DW    = 16;

    typedef struct {
        logic [LANES*DW-1:0] x;
        logic [6:0]          cnt;
    } exp_t;

    // One table row: the vector stimulus and the m_count it must produce.
    typedef struct {
        int          n;
        logic [15:0] base;
        logic [15:0] step;
        bit          last;
        bit          gaps;
        logic [6:0]  exp_cnt;
    } vrec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                s_valid, s_ready, s_last;
    logic [DW-1:0]       s_data;
    logic [LANES*DW-1:0] m_x;
    logic                m_valid, m_ready;
    logic [6:0]          m_count;

    int   n_cmp = 0, n_err = 0;
    int   cyc = 0;
    int   mv_cyc, srl_cyc;
    bit   cnt_en = 0, rand_rdy = 0;
    exp_t sb[$];

    fp16_vec64_packer #(.LANES(LANES), .DW(DW)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_x(m_x), .m_valid(m_valid),
        .m_ready(m_ready), .m_count(m_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [LANES*DW-1:0] got,
                           input logic [LANES*DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            for (int k = 0; k < LANES; k++)
                if (got[k*DW +: DW] !== exp[k*DW +: DW]) begin
                    $display("FAIL %s: lane %0d got %h expected %h", name, k,
                             got[k*DW +: DW], exp[k*DW +: DW]);
                    break;
                end
        end
    endtask

    function automatic exp_t mk_exp(input int n, input logic [15:0] base, input logic [15:0] step);
        exp_t e;
        e.x   = '0;
        e.cnt = 7'(n);
        for (int j = 0; j < n; j++) e.x[j*DW +: DW] = base + 16'(j) * step;
        return e;
    endfunction

    // Scoreboard check on every handshake.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_vector: got count %0d expected no vector", m_count);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk_vec("vec_data", m_x, e.x);
                chk("vec_count", 32'(m_count), 32'(e.cnt));
            end
        end
        if (cnt_en) begin
            if (m_valid)  mv_cyc++;
            if (!s_ready) srl_cyc++;
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    // Called at posedge+2. Returns at posedge+2 after the element is accepted.
    task automatic send_elem(input logic [15:0] d, input bit l);
        int t = 0;
        s_valid = 1'b1; s_data = d; s_last = l;
        while (!s_ready && t < 300) begin
            @(posedge clk); #2; t++;
        end
        if (!s_ready) begin
            n_cmp++; n_err++;
            $display("FAIL s_ready_timeout: got 0 expected 1 within 300 cycles");
        end
        @(posedge clk); #2;
        s_valid = 1'b0; s_data = 16'($urandom); s_last = 1'($urandom);
    endtask

    task automatic send_vec(input int n, input logic [15:0] base, input logic [15:0] step,
                            input bit last, input bit gaps);
        for (int j = 0; j < n; j++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
            send_elem(base + 16'(j) * step, last && (j == n - 1));
        end
    endtask

    vrec_t tbl [8];

    initial begin
        exp_t e;
        int   t0, bad;

        tbl[0] = '{3,  16'h4000, 16'h0200, 1'b1, 1'b0, 7'd3};
        tbl[1] = '{1,  16'hBC00, 16'h0000, 1'b1, 1'b0, 7'd1};
        tbl[2] = '{64, 16'h3C00, 16'h0000, 1'b0, 1'b0, 7'd64};
        tbl[3] = '{2,  16'h4800, 16'h0001, 1'b1, 1'b0, 7'd2};
        tbl[4] = '{64, 16'h1000, 16'h0003, 1'b1, 1'b0, 7'd64};
        tbl[5] = '{17, 16'h5555, 16'h0101, 1'b1, 1'b1, 7'd17};
        tbl[6] = '{63, 16'h2000, 16'h0001, 1'b1, 1'b1, 7'd63};
        tbl[7] = '{5,  16'hC000, 16'h0010, 1'b1, 1'b1, 7'd5};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_count", 32'(m_count), 0);
        chk_vec("rst_m_x", m_x, '0);
        rst = 1'b0;
        #1 chk("s_ready_before_edge", 32'(s_ready), 0);
        @(posedge clk); #2;
        chk("s_ready_after_edge", 32'(s_ready), 1);

        // Full vector back-to-back: exactly one FULL cycle.
        mv_cyc = 0; srl_cyc = 0; cnt_en = 1;
        sb.push_back(mk_exp(64, 16'h3C00, 16'h0000));
        send_vec(64, 16'h3C00, 16'h0000, 1'b0, 1'b0);
        repeat (4) begin @(posedge clk); #2; end
        cnt_en = 0;
        chk("full_m_valid_cycles", 32'(mv_cyc), 1);
        chk("full_s_ready_low_cycles", 32'(srl_cyc), 1);

        // Two 4-element vectors: the second start stalls for one cycle.
        t0 = cyc;
        sb.push_back(mk_exp(4, 16'h3400, 16'h0100));
        send_vec(4, 16'h3400, 16'h0100, 1'b1, 1'b0);
        sb.push_back(mk_exp(4, 16'h3800, 16'h0100));
        send_vec(4, 16'h3800, 16'h0100, 1'b1, 1'b0);
        chk("throughput_cycles", 32'(cyc - t0), 9);

        // Table of vectors under random backpressure.
        rand_rdy = 1;
        foreach (tbl[i]) begin
            e = mk_exp(tbl[i].n, tbl[i].base, tbl[i].step);
            e.cnt = tbl[i].exp_cnt;
            sb.push_back(e);
            send_vec(tbl[i].n, tbl[i].base, tbl[i].step, tbl[i].last, tbl[i].gaps);
        end
        for (int t = 0; t < 500 && sb.size() > 0; t++) begin @(posedge clk); #2; end
        rand_rdy = 0; m_ready = 1'b1;
        chk("table_drained", 32'(sb.size()), 0);

        // s_data and s_last are ignored while s_valid is low.
        sb.push_back(mk_exp(4, 16'h4400, 16'h0001));
        send_elem(16'h4400, 1'b0);
        send_elem(16'h4401, 1'b0);
        repeat (3) begin s_last = 1'b1; s_data = 16'hDEAD; @(posedge clk); #2; end
        send_elem(16'h4402, 1'b0);
        send_elem(16'h4403, 1'b1);
        repeat (3) begin @(posedge clk); #2; end

        // Backpressure for 10 cycles.
        m_ready = 1'b0;
        e = mk_exp(4, 16'h6000, 16'h0100);
        sb.push_back(e);
        send_vec(4, 16'h6000, 16'h0100, 1'b1, 1'b0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(m_valid === 1'b1 && s_ready === 1'b0 && m_x === e.x && m_count === 7'd4)) bad++;
        end
        chk("bp_stable_bad_cycles", 32'(bad), 0);
        @(posedge clk); #2;
        m_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_resume_s_ready", 32'(s_ready), 1);
        chk("bp_resume_m_valid", 32'(m_valid), 0);

        // Reset in the middle of a fill.
        for (int j = 0; j < 30; j++) send_elem(16'h7000 + 16'(j), 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_fill_m_valid", 32'(m_valid), 0);
        chk("rst_fill_s_ready", 32'(s_ready), 0);
        chk_vec("rst_fill_m_x", m_x, '0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        sb.push_back(mk_exp(64, 16'h3800, 16'h0001));
        send_vec(64, 16'h3800, 16'h0001, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #2; end

        // Reset while a vector is being held.
        m_ready = 1'b0;
        sb.push_back(mk_exp(3, 16'h5000, 16'h0001));
        send_vec(3, 16'h5000, 16'h0001, 1'b1, 1'b0);
        @(posedge clk); #2;
        chk("held_m_valid", 32'(m_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_full_m_valid", 32'(m_valid), 0);
        chk("rst_full_m_count", 32'(m_count), 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0; m_ready = 1'b1;
        @(posedge clk); #2;
        sb.push_back(mk_exp(2, 16'hABCD, 16'h0002));
        send_vec(2, 16'hABCD, 16'h0002, 1'b1, 1'b0);

        for (int t = 0; t < 100 && sb.size() > 0; t++) begin @(posedge clk); #2; end
        chk("final_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fp16_vec64_packer.md
FP16_VEC64_PACKER -- requirements
Module: fp16_vec64_packer

Interface
REQ-001 SHALL have parameter LANES, default 64, number of FP16 lanes per output vector (legal values 2..64).
REQ-002 SHALL have parameter DW, default 16, lane width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port s_valid  input  1  upstream element valid.
REQ-006 SHALL have port s_ready  output  1  packer accepts an element this cycle.
REQ-007 SHALL have port s_data  input  DW  FP16 element.
REQ-008 SHALL have port s_last  input  1  element is the final one of a short vector.
REQ-009 SHALL have port m_x  output  LANES*DW  packed vector; lane k at bits [k*DW +: DW].
REQ-010 SHALL have port m_valid  output  1  m_x holds a complete vector (drives the adder tree's x_valid).
REQ-011 SHALL have port m_ready  input  1  downstream accepts (driven by the adder tree's sum_ready_all).
REQ-012 SHALL have port m_count  output  7  number of real elements in m_x, 1..LANES.

Function
REQ-013 SHALL implement a two-state FSM: FILL (collecting) and FULL (presenting).
REQ-014 SHALL accept an element on the rising edge where s_valid && s_ready.
REQ-015 SHALL drive s_ready = 1 only in FILL; s_ready SHALL be 0 throughout FULL, with no combinational path from m_ready to s_ready.
REQ-016 SHALL write the element accepted at fill index i (0-based) into lane i, then increment the index.
REQ-017 SHALL transition FILL->FULL on acceptance of an element with index LANES-1 or with s_last=1, whichever comes first.
REQ-018 SHALL assert m_valid (registered) the cycle after the transition-causing acceptance, and hold m_valid, m_x and m_count stable while m_valid && !m_ready.
REQ-019 SHALL transition FULL->FILL on the edge where m_valid && m_ready, deasserting m_valid and resetting the fill index to 0 on that edge.
REQ-020 SHALL output 16'h0000 (FP16 +0) on every lane at index >= m_count, so short vectors sum correctly.
REQ-021 SHALL set m_count = fill index + 1 of the closing element.
REQ-022 Acceptance of the element at index LANES-1 without s_last SHALL close the vector; the next accepted element SHALL start a new vector at lane 0, with no error indication.
REQ-023 s_last on the element at index 0 SHALL produce a one-element vector: m_count=1, lanes 1..LANES-1 zero.
REQ-024 SHALL ignore s_data and s_last when s_valid=0 or s_ready=0.
REQ-025 Throughput: one vector per N+1 cycles for N elements under continuous valid/ready (one FULL cycle per vector).
REQ-026 No stale data from a previous vector SHALL appear in any lane of a new vector.

Reset
REQ-027 While rst=1: state=FILL, fill index=0, m_valid=0, m_count=0, m_x all zero, s_ready=0.
REQ-028 s_ready SHALL rise on the first clock edge after rst deasserts.
REQ-029 Reset asserted mid-FILL or mid-FULL SHALL discard the partial or held vector immediately, without waiting for a clock edge.

Verification
REQ-030 Full vector: 64 elements 16'h3C00 (1.0) streamed back-to-back, m_ready=1 -> s_ready low 1 cycle, m_valid high 1 cycle, every lane 16'h3C00, m_count=64.
REQ-031 Short vector: elements 16'h4000, 16'h4200, 16'h4400 with s_last on the third -> lanes 0..2 equal those values, lanes 3..63 = 16'h0000, m_count=3.
REQ-032 Backpressure: vector completes with m_ready=0 for 10 cycles -> m_valid, m_x, m_count stable; s_ready=0 for the whole interval; FILL resumes the cycle after m_ready=1.
REQ-033 Single element: s_last on the first element (16'hBC00) -> m_count=1, lane 0 = 16'hBC00, all other lanes zero.
REQ-034 Stale data: a 64-element vector followed by a 2-element short vector -> lanes 2..63 of the second vector read 16'h0000.
REQ-035 Reset mid-fill: rst pulsed after 30 elements -> m_valid=0, s_ready=0 during reset; the next 64 elements form a clean vector starting at lane 0.
